pe_arr_ctrl: RTL and testbench
==============================

PE_ARR_CTRL -- requirements
Module: pe_arr_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning array rows (activation lanes).
REQ-002 SHALL have parameter COLS, default 8, meaning array columns (weight lanes).
REQ-003 SHALL have parameter KMAX, default 256, meaning maximum reduction depth; AW = $clog2(KMAX).
REQ-004 SHALL have parameter DRAIN_CYC, default ROWS+COLS, meaning cycles waited after the last fire before readout.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have ports start  input  1  and k_len  input  AW+1  (reduction depth, legal 1..KMAX).
REQ-008 SHALL have ports busy  output  1  and done  output  1  (one-cycle completion pulse).
REQ-009 SHALL have ports buf_rd_en  output  1,  buf_addr  output  AW,  buf_w  input  COLS*8,  buf_a  input  ROWS*8; buffer data is valid the cycle after buf_rd_en.
REQ-010 SHALL have ports arr_clr  output  1  (accumulator clear),  arr_fire  output  1,  arr_w  output  COLS*8,  arr_a  output  ROWS*8,  arr_res  input  ROWS*COLS*32  (row-major, element r*COLS+c).
REQ-011 SHALL have ports out_valid  output  1,  out_ready  input  1,  out_row  output  $clog2(ROWS),  out_data  output  COLS*32.

Function
REQ-012 SHALL implement states IDLE, CLEAR, FEED, DRAIN, READ, DONE.
REQ-013 IDLE: start=1 with 1<=k_len<=KMAX latches k_len and goes to CLEAR; start with k_len=0 or >KMAX is ignored.
REQ-014 CLEAR lasts exactly one cycle with arr_clr=1, then FEED.
REQ-015 FEED: buf_rd_en=1 and buf_addr=0,1,...,k_len-1 on k_len consecutive cycles.
REQ-016 Lane 0 data SHALL reach arr_w/arr_a exactly one cycle after its read; arr_fire=1 on exactly those k_len cycles.
REQ-017 Skew: arr_a lane r SHALL be buf_a lane r delayed r extra cycles; arr_w lane c SHALL be buf_w lane c delayed c extra cycles; lanes carrying no valid data SHALL be zero.
REQ-018 FEED ends once the last skewed lane (max(ROWS,COLS)-1 extra delay) has emitted its final word; then DRAIN.
REQ-019 DRAIN lasts exactly DRAIN_CYC cycles with arr_fire=0 and zero lanes, then READ.
REQ-020 READ: out_valid=1, out_row=0..ROWS-1, out_data = arr_res row out_row; row advances only on out_valid&&out_ready.
REQ-021 out_row/out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 After handshake of row ROWS-1 go to DONE; DONE asserts done=1 one cycle, then IDLE.
REQ-023 busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-024 Depth counter SHALL be AW+1 bits so k_len=KMAX addresses 0..KMAX-1 without wrap.

Reset
REQ-025 rstn=0 SHALL asynchronously force IDLE and set busy, done, buf_rd_en, arr_clr, arr_fire, out_valid, buf_addr, out_row, arr_w, arr_a, out_data and all skew registers to 0.
REQ-026 Reset asserted mid-operation SHALL abandon the job; after release the block accepts a new start from IDLE with no residual fire or output.

Verification
REQ-027 ROWS=COLS=2, k_len=3, all buf data 1, out_ready=1 -> arr_clr at cycle 1, reads addr 0..2 cycles 2-4, arr_fire cycles 3-5, lane 1 data cycles 4-6, two out beats, done pulse, total busy = 1+3+1+1+4+2+1 cycles.
REQ-028 k_len=0 start -> busy stays 0, no buf_rd_en, no arr_fire.
REQ-029 out_ready held 0 for 5 cycles in READ -> out_row=0 and out_data unchanged for 5 cycles, then rows advance one per ready cycle.
REQ-030 start pulsed during DRAIN -> ignored; exactly one done pulse; next start from IDLE accepted.
REQ-031 rstn dropped during FEED (addr=2) -> all outputs 0 immediately; restart with k_len=1 completes normally.
REQ-032 k_len=KMAX=256 -> buf_addr spans 0..255, exactly 256 fire cycles, no address wrap.

Source files
------------

// File: rtl/pe_arr_ctrl_if.sv
// Bundle of the controller's job, buffer, array and readout signals.
// master = controller side, slave = environment side (buffers, array, consumer).
interface pe_arr_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int KMAX = 256
);
  localparam int AW = $clog2(KMAX);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                     start;
  logic [AW:0]              k_len;
  logic                     busy;
  logic                     done;
  logic                     buf_rd_en;
  logic [AW-1:0]            buf_addr;
  logic [COLS*8-1:0]        buf_w;
  logic [ROWS*8-1:0]        buf_a;
  logic                     arr_clr;
  logic                     arr_fire;
  logic [COLS*8-1:0]        arr_w;
  logic [ROWS*8-1:0]        arr_a;
  logic [ROWS*COLS*32-1:0]  arr_res;
  logic                     out_valid;
  logic                     out_ready;
  logic [RW-1:0]            out_row;
  logic [COLS*32-1:0]       out_data;

  modport master (
    input  start, k_len, buf_w, buf_a, arr_res, out_ready,
    output busy, done, buf_rd_en, buf_addr, arr_clr, arr_fire,
           arr_w, arr_a, out_valid, out_row, out_data
  );

  modport slave (
    output start, k_len, buf_w, buf_a, arr_res, out_ready,
    input  busy, done, buf_rd_en, buf_addr, arr_clr, arr_fire,
           arr_w, arr_a, out_valid, out_row, out_data
  );
endinterface

// File: rtl/pe_arr_ctrl.sv
// Sequencer for a ROWS x COLS systolic PE array: clears accumulators, streams
// k_len buffer words into the array with a per-lane diagonal skew, waits for
// the wavefront to drain, then reads the result out one row per handshake.
module pe_arr_ctrl #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int KMAX      = 256,
  parameter int DRAIN_CYC = ROWS + COLS
) (
  input  logic             clk,
  input  logic             rstn,
  pe_arr_ctrl_if.master    bus
);

  localparam int AW   = $clog2(KMAX);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAXL = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW   = $clog2(KMAX + MAXL + DRAIN_CYC + 1) + 1;

  localparam logic [AW:0] KMAX_V = (AW+1)'(KMAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [AW:0]   k_q;
  logic [RW-1:0] row;
  logic          rd;
  logic          vld_p0;
  logic          hs;

  logic [ROWS*8-1:0] a_g;
  logic [COLS*8-1:0] w_g;
  logic [ROWS*8-1:0] a_sk;
  logic [COLS*8-1:0] w_sk;

  // A read is issued on the first k_len cycles of FEED; the rest of FEED lets the skew flush
  assign rd = (state == S_FEED) && (cnt < CW'(k_q));
  assign hs = (state == S_READ) && bus.out_ready;

  // Control FSM: job acceptance, phase sequencing and readout row tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      cnt   <= '0;
      k_q   <= '0;
      row   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.k_len != '0) && (bus.k_len <= KMAX_V)) begin
            k_q   <= bus.k_len;
            cnt   <= '0;
            state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt   <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (cnt == CW'(k_q) + CW'(MAXL - 1)) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == CW'(DRAIN_CYC - 1)) begin
            cnt   <= '0;
            row   <= '0;
            state <= S_READ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ: begin
          if (hs) begin
            if (row == RW'(ROWS - 1)) begin
              row   <= '0;
              state <= S_DONE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage p0 valid: buffer data returned this cycle belongs to a read from the previous cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd;
    end
  end

  // ---- stage p0: buffer data gated by its valid, so idle lanes carry zero ----
  assign a_g = vld_p0 ? bus.buf_a : '0;
  assign w_g = vld_p0 ? bus.buf_w : '0;

  // ---- skew stages: lane n is delayed n cycles to form the systolic wavefront ----
  for (genvar r = 0; r < ROWS; r++) begin : g_a
    if (r == 0) begin : g_0
      assign a_sk[7:0] = a_g[7:0];
    end else begin : g_d
      logic [7:0] sh [r];
      // Shift chain for activation lane r
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < r; i++) sh[i] <= '0;
        end else begin
          sh[0] <= a_g[r*8 +: 8];
          for (int i = 1; i < r; i++) sh[i] <= sh[i-1];
        end
      end
      assign a_sk[r*8 +: 8] = sh[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_w
    if (c == 0) begin : g_0
      assign w_sk[7:0] = w_g[7:0];
    end else begin : g_d
      logic [7:0] sh [c];
      // Shift chain for weight lane c
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < c; i++) sh[i] <= '0;
        end else begin
          sh[0] <= w_g[c*8 +: 8];
          for (int i = 1; i < c; i++) sh[i] <= sh[i-1];
        end
      end
      assign w_sk[c*8 +: 8] = sh[c-1];
    end
  end

  // ---- outputs ----
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.arr_clr   = (state == S_CLEAR);
  assign bus.buf_rd_en = rd;
  assign bus.buf_addr  = rd ? cnt[AW-1:0] : '0;
  assign bus.arr_fire  = vld_p0;
  assign bus.arr_a     = a_sk;
  assign bus.arr_w     = w_sk;
  assign bus.out_valid = (state == S_READ);
  assign bus.out_row   = row;
  assign bus.out_data  = (state == S_READ) ? bus.arr_res[int'(row)*COLS*32 +: COLS*32] : '0;

endmodule

// File: tb/tb_pe_arr_ctrl.sv
// Directed + randomized bench for pe_arr_ctrl (2x2 array, KMAX=256).
module tb_pe_arr_ctrl;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int KMAX = 256;
  localparam int MAXL = 2;
  localparam int DRN  = ROWS + COLS;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;

  logic [15:0]  mem_a [KMAX];
  logic [15:0]  mem_w [KMAX];
  logic [127:0] res_v;

  pe_arr_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) bus ();

  pe_arr_ctrl #(.ROWS(ROWS), .COLS(COLS), .KMAX(KMAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_rd"},    bus.buf_rd_en, 0);
    chk({tag, "_addr"},  bus.buf_addr, 0);
    chk({tag, "_clr"},   bus.arr_clr, 0);
    chk({tag, "_fire"},  bus.arr_fire, 0);
    chk({tag, "_arr_a"}, bus.arr_a, 0);
    chk({tag, "_arr_w"}, bus.arr_w, 0);
    chk({tag, "_ovld"},  bus.out_valid, 0);
    chk({tag, "_orow"},  bus.out_row, 0);
    chk({tag, "_odata"}, bus.out_data, 0);
  endtask

  // Idle cycles: nothing may start, read, fire or output.
  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_rd"},   bus.buf_rd_en, 0);
      chk({tag, "_fire"}, bus.arr_fire, 0);
      chk({tag, "_ovld"}, bus.out_valid, 0);
    end
  endtask

  // One job, checked cycle by cycle against a schedule derived from k:
  // cycle 1 clear, reads at 2..k+1, lane n data at 3+n..k+2+n, drain, then
  // readout gated by out_ready, then a single done cycle.
  task automatic run_job(input string tag, input int k, input int stall, input bit rrand,
                         input int poke_j, input int abort_j, output int nbusy);
    int j, row, done_j, read_start, id;
    bit fin, in_read, rdy;
    logic [15:0] ea, ew;
    logic [63:0] ed;
    for (int i = 0; i < KMAX; i++) begin
      mem_a[i] = 16'($urandom);
      mem_w[i] = 16'($urandom);
    end
    res_v = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.arr_res = res_v;
    nbusy = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = 9'(k);
    @(posedge clk); #1;
    bus.start = 1'b0;
    j = 1; row = 0; done_j = -1; fin = 1'b0;
    read_start = 2 + k + MAXL + DRN;
    while (!fin) begin
      id = j - 3;
      if (id >= 0 && id < k) begin
        bus.buf_a = mem_a[id];
        bus.buf_w = mem_w[id];
      end else begin
        bus.buf_a = 16'($urandom);
        bus.buf_w = 16'($urandom);
      end
      in_read = (j >= read_start) && (row < ROWS);
      if (j - read_start < stall) rdy = 1'b0;
      else rdy = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      bus.start = (j == poke_j);
      bus.k_len = 9'd3;
      #1;
      ea = '0; ew = '0;
      for (int r = 0; r < 2; r++) begin
        id = j - 3 - r;
        if (id >= 0 && id < k) begin
          ea[r*8 +: 8] = mem_a[id][r*8 +: 8];
          ew[r*8 +: 8] = mem_w[id][r*8 +: 8];
        end
      end
      ed = in_read ? res_v[row*64 +: 64] : 64'd0;
      if (bus.busy === 1'b1) nbusy++;
      chk({tag, "_busy"},  bus.busy, 1);
      chk({tag, "_done"},  bus.done, (j == done_j));
      chk({tag, "_clr"},   bus.arr_clr, (j == 1));
      chk({tag, "_rd"},    bus.buf_rd_en, (j >= 2 && j <= k + 1));
      chk({tag, "_addr"},  bus.buf_addr, (j >= 2 && j <= k + 1) ? j - 2 : 0);
      chk({tag, "_fire"},  bus.arr_fire, (j >= 3 && j <= k + 2));
      chk({tag, "_arr_a"}, bus.arr_a, ea);
      chk({tag, "_arr_w"}, bus.arr_w, ew);
      chk({tag, "_ovld"},  bus.out_valid, in_read);
      chk({tag, "_orow"},  bus.out_row, in_read ? row : 0);
      chk({tag, "_odata"}, bus.out_data, ed);
      if (j == abort_j) begin
        bus.start = 1'b0;
        rstn = 1'b0;
        #1;
        chk_all_zero({tag, "_rst"});
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        return;
      end
      if (in_read && rdy) begin
        row++;
        if (row == ROWS) done_j = j + 1;
      end
      if (j == done_j) fin = 1'b1;
      if (j > 4000) begin
        total++; bad++;
        $display("FAIL %s_timeout observed=running expected=finished", tag);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      j++;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk({tag, "_end_busy"}, bus.busy, 0);
    chk({tag, "_end_done"}, bus.done, 0);
  endtask

  initial begin
    int nb;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.buf_a = '0;
    bus.buf_w = '0;
    bus.arr_res = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.out_ready = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Illegal depths are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = 9'd0;
    idle_cycles("k0", 4);
    @(negedge clk);
    bus.k_len = 9'd257;
    idle_cycles("k257", 3);
    @(negedge clk);
    bus.start = 1'b0;

    // Basic job: k=3, always ready; busy spans clear+feed+skew+drain+read+done
    run_job("basic", 3, 0, 1'b0, -1, -1, nb);
    chk("basic_busy_len", nb, 1 + 3 + 1 + 1 + 4 + 2 + 1);

    // Consumer stalls 5 cycles at the start of readout, then random ready
    run_job("stall", 5, 5, 1'b1, -1, -1, nb);

    // Start pulsed during drain is ignored; next start accepted
    run_job("poke", 3, 0, 1'b0, 8, -1, nb);
    run_job("after_poke", 2, 0, 1'b0, -1, -1, nb);

    // Random depths with random readout backpressure
    for (int t = 0; t < 4; t++) begin
      run_job("rand", $urandom_range(1, 20), $urandom_range(0, 3), 1'b1, -1, -1, nb);
    end

    // Reset while feeding address 2 abandons the job
    run_job("abort", 5, 0, 1'b0, -1, 4, nb);
    idle_cycles("post_rst", 3);
    run_job("restart", 1, 0, 1'b0, -1, -1, nb);

    // Full depth
    run_job("kmax", KMAX, 0, 1'b1, -1, -1, nb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
